// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the 5-stage MIPS pipeline.
//
// The decode-side timing table gives each instruction two kinds of number:
//   T_use : how many cycles after D an operand is first consumed
//           (0=D, 1=E, 2=M, 7=never)
//   T_new : how many cycles after entering E the result becomes available
//
// The block keeps its own copy of the destination and T_new of the
// instructions in E, M and W, and ages T_new by one at each stage. From that
// copy it produces:
//   - a D-stage stall when a result cannot be ready in time, or when the
//     instruction in D needs hi/lo while the mult/div unit is still busy
//   - forwarding selects for the D and E operand muxes
//   - a busy interlock for the multi-cycle mult/div unit
//
// Ports:
//   clk, reset               core clock; synchronous active-high reset
//   D_rs, D_rt               source register numbers of the D instruction
//   D_rs_tuse, D_rt_tuse     T_use of each source (7 = not used)
//   D_wa, D_tnew             destination (0 = none) and T_new of D instruction
//   D_md_use                 D instruction reads or writes hi/lo
//   D_md_start               01 mult/multu, 10 div/divu, otherwise none
//   stall                    freeze PC and F/D, inject a bubble into E
//   fwd_D_rs, fwd_D_rt       D operand source: 0 regfile, 1 M result, 2 W result
//   fwd_E_rs, fwd_E_rt       E operand source: 0 pipeline reg, 1 M, 2 W
//   md_busy                  mult/div unit still counting
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [2:0] D_rs_tuse,
    input  logic [2:0] D_rt_tuse,
    input  logic [4:0] D_wa,
    input  logic [2:0] D_tnew,
    input  logic       D_md_use,
    input  logic [1:0] D_md_start,
    output logic       stall,
    output logic [1:0] fwd_D_rs,
    output logic [1:0] fwd_D_rt,
    output logic [1:0] fwd_E_rs,
    output logic [1:0] fwd_E_rt,
    output logic       md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // Stage copies. Only E needs its source registers (for E forwarding);
    // M and W only need to say what they write and when it is ready.
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic [4:0]       e_wa_q, e_wa_d;
    logic [2:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       m_wa_q, m_wa_d;
    logic [2:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_wa_q, w_wa_d;
    logic [2:0]       w_tnew_q, w_tnew_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    // A producer blocks a consumer when its result is still further away
    // than the consumer's first use. tuse=7 can never be exceeded by a 3-bit
    // tnew, so unused operands never hit.
    function automatic logic reg_hit(input logic [4:0] src, input logic [2:0] tuse,
                                     input logic [4:0] wa,  input logic [2:0] tnew);
        return (src != 5'd0) && (src == wa) && (tnew > tuse);
    endfunction

    // Forward only results that are already computed (tnew aged to 0).
    // M is the younger producer, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mwa, input logic [2:0] mtnew,
                                           input logic [4:0] wwa, input logic [2:0] wtnew);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0 && src == mwa && mtnew == 3'd0) begin
            sel = 2'd1;
        end else if (src != 5'd0 && src == wwa && wtnew == 3'd0) begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        stall = reg_hit(D_rs, D_rs_tuse, e_wa_q, e_tnew_q)
              | reg_hit(D_rs, D_rs_tuse, m_wa_q, m_tnew_q)
              | reg_hit(D_rt, D_rt_tuse, e_wa_q, e_tnew_q)
              | reg_hit(D_rt, D_rt_tuse, m_wa_q, m_tnew_q)
              | (D_md_use && (md_cnt_q != '0));

        md_busy  = (md_cnt_q != '0);
        fwd_D_rs = fwd_sel(D_rs,   m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
        fwd_D_rt = fwd_sel(D_rt,   m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
        fwd_E_rs = fwd_sel(e_rs_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
        fwd_E_rt = fwd_sel(e_rt_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);

        // A stalled D instruction becomes an all-zero bubble in E.
        e_rs_d   = stall ? 5'd0 : D_rs;
        e_rt_d   = stall ? 5'd0 : D_rt;
        e_wa_d   = stall ? 5'd0 : D_wa;
        e_tnew_d = stall ? 3'd0 : D_tnew;

        // Ageing saturates at zero.
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q == 3'd0) ? 3'd0 : e_tnew_q - 3'd1;
        w_wa_d   = m_wa_q;
        w_tnew_d = (m_tnew_q == 3'd0) ? 3'd0 : m_tnew_q - 3'd1;

        // Load on entry to E has priority; code 11 behaves as no start.
        md_cnt_d = md_cnt_q;
        if (!stall && D_md_start == 2'b01) begin
            md_cnt_d = MULT_LOAD;
        end else if (!stall && D_md_start == 2'b10) begin
            md_cnt_d = DIV_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            e_wa_q   <= 5'd0;
            e_tnew_q <= 3'd0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 3'd0;
            w_wa_q   <= 5'd0;
            w_tnew_q <= 3'd0;
            md_cnt_q <= '0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            w_wa_q   <= w_wa_d;
            w_tnew_q <= w_tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios for the documented hazard cases, then randomized traffic
// checked against a reference model. The model records every instruction as it
// enters E in a queue (front = E, then M, then W); a producer's remaining
// latency is its tnew minus its age in the queue, floored at zero. The
// mult/div unit is modelled as the cycle number at which it becomes free.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_wa;
    logic [2:0] D_rs_tuse, D_rt_tuse, D_tnew;
    logic       D_md_use;
    logic [1:0] D_md_start;
    logic       stall, md_busy;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rs_tuse (D_rs_tuse),
        .D_rt_tuse (D_rt_tuse),
        .D_wa      (D_wa),
        .D_tnew    (D_tnew),
        .D_md_use  (D_md_use),
        .D_md_start(D_md_start),
        .stall     (stall),
        .fwd_D_rs  (fwd_D_rs),
        .fwd_D_rt  (fwd_D_rt),
        .fwd_E_rs  (fwd_E_rs),
        .fwd_E_rt  (fwd_E_rt),
        .md_busy   (md_busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        int         tnew;
    } ent_t;

    ent_t pipe_q[$];
    int   cyc      = 0;
    int   busy_end = 0;

    initial begin
        repeat (3) pipe_q.push_back('{rs: '0, rt: '0, wa: '0, tnew: 0});
    end

    function automatic int eff_tnew(int age);
        return (pipe_q[age].tnew > age) ? pipe_q[age].tnew - age : 0;
    endfunction

    function automatic bit model_busy();
        return cyc < busy_end;
    endfunction

    function automatic bit model_hit(logic [4:0] src, logic [2:0] tuse);
        bit h;
        h = 1'b0;
        for (int a = 0; a < 2; a++) begin
            if (src != 5'd0 && src == pipe_q[a].wa && eff_tnew(a) > int'(tuse)) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [1:0] model_fwd(logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (src == pipe_q[1].wa && eff_tnew(1) == 0) return 2'd1;
        if (src == pipe_q[2].wa && eff_tnew(2) == 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        return model_hit(D_rs, D_rs_tuse) || model_hit(D_rt, D_rt_tuse) ||
               (D_md_use && model_busy());
    endfunction

    always @(posedge clk) begin
        bit   s;
        ent_t e;
        if (reset) begin
            pipe_q.delete();
            repeat (3) pipe_q.push_back('{rs: '0, rt: '0, wa: '0, tnew: 0});
            busy_end = 0;
        end else begin
            s = model_stall();
            if (s) e = '{rs: '0, rt: '0, wa: '0, tnew: 0};
            else   e = '{rs: D_rs, rt: D_rt, wa: D_wa, tnew: int'(D_tnew)};
            pipe_q.push_front(e);
            void'(pipe_q.pop_back());
            if (!s && D_md_start == 2'b01)      busy_end = cyc + 1 + MULT_CYCLES;
            else if (!s && D_md_start == 2'b10) busy_end = cyc + 1 + DIV_CYCLES;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_d(input logic [4:0] rs, input logic [2:0] rsu,
                         input logic [4:0] rt, input logic [2:0] rtu,
                         input logic [4:0] wa, input logic [2:0] tn,
                         input logic mu, input logic [1:0] ms);
        D_rs = rs; D_rs_tuse = rsu; D_rt = rt; D_rt_tuse = rtu;
        D_wa = wa; D_tnew = tn; D_md_use = mu; D_md_start = ms;
    endtask

    task automatic nop();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd0, 1'b0, 2'b00);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd1, 3'd2, 1'b0, 2'b00);   // lw $1
        step();
        set_d(5'd1, 3'd1, 5'd0, 3'd7, 5'd2, 3'd1, 1'b0, 2'b00);   // add rs=$1
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_stall: got %b want 1", stall); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests_run++;
        if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_fwd: got %h want 00", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt});
        end
        tests_run++;
        if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        nop();
        step();
    endtask

    task automatic test_load_use();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd1, 3'd2, 1'b0, 2'b00);   // lw $1
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
        step();
        set_d(5'd1, 3'd1, 5'd0, 3'd7, 5'd2, 3'd1, 1'b0, 2'b00);   // add rs=$1
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL lu_stall1: got %b want 1", stall); end
        step();
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL lu_stall2: got %b want 0", stall); end
        step();
        nop();
        #1;
        tests_run++;
        if (fwd_E_rs !== 2'd2) begin tests_failed++; $display("FAIL lu_fwd_E_rs: got %0d want 2", fwd_E_rs); end
        step();
    endtask

    task automatic test_alu_branch();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd3, 3'd1, 1'b0, 2'b00);   // add $3
        step();
        set_d(5'd3, 3'd0, 5'd0, 3'd7, 5'd0, 3'd0, 1'b0, 2'b00);   // beq rs=$3
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL br_stall: got %b want 1", stall); end
        step();
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL br_release: got %b want 0", stall); end
        tests_run++;
        if (fwd_D_rs !== 2'd1) begin tests_failed++; $display("FAIL br_fwd_D_rs: got %0d want 1", fwd_D_rs); end
        nop();
        step();
    endtask

    task automatic test_store_data();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd4, 3'd1, 1'b0, 2'b00);   // ori $4
        step();
        set_d(5'd0, 3'd7, 5'd4, 3'd2, 5'd0, 3'd0, 1'b0, 2'b00);   // sw rt=$4
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL sw_stall: got %b want 0", stall); end
        step();
        nop();
        #1;
        tests_run++;
        if (fwd_E_rt !== 2'd1) begin tests_failed++; $display("FAIL sw_fwd_E_rt: got %0d want 1", fwd_E_rt); end
        step();
    endtask

    task automatic test_zero_reg();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd2, 1'b0, 2'b00);   // lw $0
        step();
        set_d(5'd0, 3'd1, 5'd0, 3'd0, 5'd2, 3'd1, 1'b0, 2'b00);   // add rs=$0
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL zero_stall: got %b want 0", stall); end
        step();
        nop();
        step();
        #1;
        tests_run++;
        if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt} !== 8'h00) begin
            tests_failed++;
            $display("FAIL zero_fwd: got %h want 00", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt});
        end
        step();
    endtask

    task automatic test_mult_mfhi();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd0, 1'b1, 2'b01);   // mult
        #1;
        tests_run++;
        if ({stall, md_busy} !== 2'b00) begin tests_failed++; $display("FAIL mult_issue: got %b want 00", {stall, md_busy}); end
        step();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd5, 3'd1, 1'b1, 2'b00);   // mfhi $5
        for (int i = 0; i < MULT_CYCLES; i++) begin
            #1;
            tests_run++;
            if ({stall, md_busy} !== 2'b11) begin
                tests_failed++;
                $display("FAIL mult_busy[%0d]: got %b want 11", i, {stall, md_busy});
            end
            step();
        end
        #1;
        tests_run++;
        if ({stall, md_busy} !== 2'b00) begin tests_failed++; $display("FAIL mult_done: got %b want 00", {stall, md_busy}); end
        step();
        set_d(5'd5, 3'd0, 5'd0, 3'd7, 5'd0, 3'd0, 1'b0, 2'b00);   // beq rs=$5
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL mfhi_in_E: got %b want 1", stall); end
        nop();
        step();
        step();
    endtask

    task automatic test_div();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd0, 1'b1, 2'b10);   // div
        step();
        nop();
        for (int i = 0; i < DIV_CYCLES; i++) begin
            #1;
            tests_run++;
            if (md_busy !== 1'b1) begin tests_failed++; $display("FAIL div_busy[%0d]: got %b want 1", i, md_busy); end
            step();
        end
        #1;
        tests_run++;
        if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL div_done: got %b want 0", md_busy); end
        step();
    endtask

    task automatic test_reset_mid_div();
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd0, 1'b1, 2'b10);   // div
        step();
        nop();
        repeat (3) step();                                         // count now 7
        set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd6, 3'd1, 1'b1, 2'b00);   // mfhi $6
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL rdiv_pre_stall: got %b want 1", stall); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({stall, md_busy} !== 2'b00) begin tests_failed++; $display("FAIL rdiv_after: got %b want 00", {stall, md_busy}); end
        tests_run++;
        if ({fwd_E_rs, fwd_E_rt} !== 4'h0) begin tests_failed++; $display("FAIL rdiv_fwd_E: got %h want 0", {fwd_E_rs, fwd_E_rt}); end
        nop();
        step();
    endtask

    task automatic test_random();
        logic [2:0] tu_tab [4];
        logic [1:0] ms;
        bit         exp_stall;
        tu_tab = '{3'd0, 3'd1, 3'd2, 3'd7};
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            ms = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            set_d(5'($urandom_range(0, 3)), tu_tab[$urandom_range(0, 3)],
                  5'($urandom_range(0, 3)), tu_tab[$urandom_range(0, 3)],
                  5'($urandom_range(0, 3)), 3'($urandom_range(0, 2)),
                  (ms == 2'b01 || ms == 2'b10) ? 1'b1 : ($urandom_range(0, 3) == 0),
                  ms);
            #1;
            exp_stall = model_stall();
            tests_run++;
            if (stall !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, exp_stall); end
            tests_run++;
            if (md_busy !== model_busy()) begin tests_failed++; $display("FAIL rnd_md_busy[%0d]: got %b want %b", n, md_busy, model_busy()); end
            tests_run++;
            if (fwd_D_rs !== model_fwd(D_rs)) begin tests_failed++; $display("FAIL rnd_fwd_D_rs[%0d]: got %0d want %0d", n, fwd_D_rs, model_fwd(D_rs)); end
            tests_run++;
            if (fwd_D_rt !== model_fwd(D_rt)) begin tests_failed++; $display("FAIL rnd_fwd_D_rt[%0d]: got %0d want %0d", n, fwd_D_rt, model_fwd(D_rt)); end
            tests_run++;
            if (fwd_E_rs !== model_fwd(pipe_q[0].rs)) begin tests_failed++; $display("FAIL rnd_fwd_E_rs[%0d]: got %0d want %0d", n, fwd_E_rs, model_fwd(pipe_q[0].rs)); end
            tests_run++;
            if (fwd_E_rt !== model_fwd(pipe_q[0].rt)) begin tests_failed++; $display("FAIL rnd_fwd_E_rt[%0d]: got %0d want %0d", n, fwd_E_rt, model_fwd(pipe_q[0].rt)); end
            step();
        end
        reset = 1'b0;
        nop();
        step();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        nop();
        repeat (3) step();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_store_data();
        test_zero_reg();
        test_mult_mfhi();
        test_div();
        test_reset_mid_div();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It consumes the per-instruction T_use/T_new timing encodings produced by the decode-side timing table. It pipelines destination/T_new info through E, M and W internally. It outputs the D-stage stall, the D- and E-stage forwarding selects, and the hi/lo multiply/divide busy interlock.

Parameters:
MULT_CYCLES, 5, busy cycles charged when mult/multu enters E
DIV_CYCLES, 10, busy cycles charged when div/divu enters E
CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
D_rs  input  5  rs field of instruction in D
D_rt  input  5  rt field of instruction in D
D_rs_tuse  input  3  cycles until rs consumed (0=D, 1=E, 2=M); 7=not used
D_rt_tuse  input  3  same for rt
D_wa  input  5  destination register of D instruction (0 = none)
D_tnew  input  3  cycles after entering E until result is ready (ALU/mf=1, load=2, none=0)
D_md_use  input  1  D instruction uses hi/lo unit (mult*, div*, mfhi, mflo, mthi, mtlo)
D_md_start  input  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as 00)
stall  output  1  freeze PC and F/D register, insert bubble into E
fwd_D_rs  output  2  D-stage rs source: 0 regfile, 1 M result, 2 W result
fwd_D_rt  output  2  same for rt
fwd_E_rs  output  2  E-stage rs source: 0 registered value, 1 M result, 2 W result
fwd_E_rt  output  2  same for rt
md_busy  output  1  hi/lo unit busy (counter nonzero)

Behaviour:
- Internal stage regs E/M/W: {rs, rt, wa, tnew}. On each edge: W<=M, M<=E, E<=D-info or bubble (all fields 0) when stall=1.
- tnew aging: M.tnew <= (E.tnew==0)?0:E.tnew-1; W.tnew likewise from M. Saturates at 0, never wraps.
- Register hazard, per operand X in {rs,rt}: hit_S = (D_X!=0) && (D_X==S.wa) && (S.tnew > D_X_tuse), S in {E,M}. tuse=7 never hits. W never stalls.
- md hazard: D_md_use && md_busy.
- stall = OR of all hits and md hazard; purely combinational from inputs + state.
- D forwarding (tuse 0 consumers): 1 if D_X!=0 && D_X==M.wa && M.tnew==0; else 2 if D_X==W.wa && W.tnew==0 && D_X!=0; else 0. M has priority over W. Outputs valid even when stall=1; consumers ignore them then.
- E forwarding: same rule using E.rs/E.rt against M then W.
- Register $0: never stalls, never forwarded.
- Busy counter: when D instruction enters E (stall=0) with D_md_start=01, load MULT_CYCLES; with 10, load DIV_CYCLES. Otherwise decrement if nonzero. md_busy = (count!=0). A load takes priority over decrement. No load can occur while busy: such an instruction has D_md_use=1 and is stalled.
- Reset: E/M/W regs and counter = 0. Outputs the cycle after reset is released: stall=0 (inputs permitting), all fwd=0, md_busy=0. Reset mid-divide aborts the count immediately.

Test Plan:
- Load-use: lw $1 in D (wa=1,tnew=2), then add rs=1 tuse=1 -> stall=1 exactly 1 cycle. When add is in E: fwd_E_rs=2.
- ALU-branch: add $3 (tnew=1), then beq rs=3 tuse=0 -> stall 1 cycle. Next cycle fwd_D_rs=1.
- Store data: ori $4 (tnew=1), then sw rt=4 tuse=2 -> no stall. With sw in E: fwd_E_rt=1.
- $0 immunity: lw wa=0 tnew=2, then add rs=0 tuse=1 -> stall=0, all fwd=0.
- mult then mfhi: mult enters E -> md_busy=1 for 5 cycles. mfhi (D_md_use=1) stalls those 5 cycles and enters E on cycle 6. div gives 10 cycles.
- Reset during div (count=7): reset=1 one cycle -> count=0, md_busy=0, E/M/W cleared. Pending mfhi no longer stalls.
